// File: rtl/picorv_pkg.sv
// Shared definitions for the PicoRV issue/retire stage: FSM states,
// instruction field positions and the sequential-PC step helper.
package picorv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_TRAP   = 2'd3
    } state_e;

    localparam int REG_AW  = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RS3_LSB = 27;

    localparam logic [1:0] PREFIX_FULL = 2'b11;

    // Full-length instructions advance the PC by 4, compressed ones by 2.
    function automatic logic [2:0] pc_step(input logic [1:0] len_bits);
        return (len_bits == PREFIX_FULL) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/picorv_regfile.sv
// 32 x XLEN register file: three operand read ports plus a debug read port,
// one synchronous write port, x0 hardwired to zero, synchronous clear.
module picorv_regfile
    import picorv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] ra3,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic [XLEN-1:0]   rd3,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    assign rd1      = (ra1 == 5'd0)      ? {XLEN{1'b0}} : regs_q[ra1];
    assign rd2      = (ra2 == 5'd0)      ? {XLEN{1'b0}} : regs_q[ra2];
    assign rd3      = (ra3 == 5'd0)      ? {XLEN{1'b0}} : regs_q[ra3];
    assign dbg_data = (dbg_addr == 5'd0) ? {XLEN{1'b0}} : regs_q[dbg_addr];

    // Write-port merge; entry 0 is kept at zero so x0 can never hold data.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end else begin
            regs_d[0] = {XLEN{1'b0}};
        end
    end

    // Register storage with synchronous clear taking priority over writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/picorv_issue.sv
// PCPI initiator: accepts in-order fetch entries, broadcasts decode, issues the
// PCPI request with register operands and retires via writeback/PC update.
module picorv_issue
    import picorv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              TIMEOUT  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ILEN-1:0]   fetch_insn,
    input  logic [15:0]       fetch_prefix,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              decode_valid,
    output logic [ILEN-1:0]   decode_insn,
    output logic [15:0]       decode_prefix,
    output logic              pcpi_valid,
    output logic [ILEN-1:0]   pcpi_insn,
    output logic [15:0]       pcpi_prefix,
    output logic [XLEN-1:0]   pcpi_pc,
    output logic              pcpi_rs1_valid,
    output logic              pcpi_rs2_valid,
    output logic              pcpi_rs3_valid,
    output logic [XLEN-1:0]   pcpi_rs1_data,
    output logic [XLEN-1:0]   pcpi_rs2_data,
    output logic [XLEN-1:0]   pcpi_rs3_data,
    input  logic              pcpi_ready,
    output logic              pcpi_wb_valid,
    input  logic              pcpi_wb_write,
    input  logic [XLEN-1:0]   pcpi_wb_data,
    input  logic              pcpi_br_enable,
    input  logic [XLEN-1:0]   pcpi_br_nextpc,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              retire_valid,
    output logic [XLEN-1:0]   retire_pc,
    output logic              trap,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [ILEN-1:0]   insn_q, insn_d;
    logic [15:0]       prefix_q, prefix_d;
    logic [XLEN-1:0]   ipc_q, ipc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fetch_ready_q, fetch_ready_d;
    logic              decode_valid_q, decode_valid_d;
    logic              pcpi_valid_q, pcpi_valid_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              retire_valid_q, retire_valid_d;
    logic [XLEN-1:0]   retire_pc_q, retire_pc_d;
    logic              trap_q, trap_d;
    logic              wb_we;
    logic [REG_AW-1:0] rd_idx;

    assign rd_idx = insn_q[RD_LSB +: REG_AW];

    picorv_regfile #(.XLEN(XLEN)) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .ra1      (insn_q[RS1_LSB +: REG_AW]),
        .ra2      (insn_q[RS2_LSB +: REG_AW]),
        .ra3      (insn_q[RS3_LSB +: REG_AW]),
        .dbg_addr (dbg_addr),
        .rd1      (pcpi_rs1_data),
        .rd2      (pcpi_rs2_data),
        .rd3      (pcpi_rs3_data),
        .dbg_data (dbg_data),
        .we       (wb_we),
        .wa       (rd_idx),
        .wd       (pcpi_wb_data)
    );

    // Next-state, retire and writeback decisions for the issue FSM.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        insn_d           = insn_q;
        prefix_d         = prefix_q;
        ipc_d            = ipc_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        retire_valid_d   = 1'b0;
        retire_pc_d      = retire_pc_q;
        wb_we            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Entries not at the expected PC are wrong-path and simply consumed.
                if (fetch_valid && fetch_ready_q && (fetch_pc == pc_q)) begin
                    insn_d   = fetch_insn;
                    prefix_d = fetch_prefix;
                    ipc_d    = fetch_pc;
                    state_d  = ST_DECODE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DECODE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (pcpi_ready) begin
                    wb_we          = pcpi_wb_write && (rd_idx != 5'd0);
                    retire_valid_d = 1'b1;
                    retire_pc_d    = ipc_q;
                    state_d        = ST_IDLE;
                    if (pcpi_br_enable) begin
                        pc_d             = pcpi_br_nextpc;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = pcpi_br_nextpc;
                    end else begin
                        pc_d = ipc_q + XLEN'(pc_step(prefix_q[1:0]));
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fetch_ready_d  = (state_d == ST_IDLE);
        decode_valid_d = (state_d == ST_DECODE);
        pcpi_valid_d   = (state_d == ST_EXEC);
        trap_d         = (state_d == ST_TRAP);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            pc_q             <= RESET_PC;
            insn_q           <= {ILEN{1'b0}};
            prefix_q         <= 16'd0;
            ipc_q            <= {XLEN{1'b0}};
            cnt_q            <= {CNT_W{1'b0}};
            fetch_ready_q    <= 1'b0;
            decode_valid_q   <= 1'b0;
            pcpi_valid_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            retire_valid_q   <= 1'b0;
            retire_pc_q      <= {XLEN{1'b0}};
            trap_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            insn_q           <= insn_d;
            prefix_q         <= prefix_d;
            ipc_q            <= ipc_d;
            cnt_q            <= cnt_d;
            fetch_ready_q    <= fetch_ready_d;
            decode_valid_q   <= decode_valid_d;
            pcpi_valid_q     <= pcpi_valid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            retire_valid_q   <= retire_valid_d;
            retire_pc_q      <= retire_pc_d;
            trap_q           <= trap_d;
        end
    end

    assign fetch_ready    = fetch_ready_q;
    assign decode_valid   = decode_valid_q;
    assign decode_insn    = insn_q;
    assign decode_prefix  = prefix_q;
    assign pcpi_valid     = pcpi_valid_q;
    assign pcpi_insn      = insn_q;
    assign pcpi_prefix    = prefix_q;
    assign pcpi_pc        = ipc_q;
    assign pcpi_rs1_valid = pcpi_valid_q;
    assign pcpi_rs2_valid = pcpi_valid_q;
    assign pcpi_rs3_valid = pcpi_valid_q;
    assign pcpi_wb_valid  = pcpi_valid_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign retire_valid   = retire_valid_q;
    assign retire_pc      = retire_pc_q;
    assign trap           = trap_q;

endmodule

// File: doc/picorv_issue.md
# picorv_issue

Issue/retire stage of the PicoRV core: the PCPI initiator. Accepts fetched instructions, broadcasts them on the decode bus, and drives the PCPI request with operands from an internal 32-entry register file. It waits for the executing unit's ready, then performs register writeback and PC update or redirect. Sits between the fetch queue and the PCPI execution units.

## Interface
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- RESET_PC, 0, PC after reset
- TIMEOUT, 16, EXEC cycles without pcpi_ready before trap
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_valid / fetch_ready  in / out  1  fetch handshake
- fetch_insn, fetch_prefix, fetch_pc  in  ILEN, 16, XLEN  fetched entry
- decode_valid  out  1  one-cycle decode broadcast
- decode_insn, decode_prefix  out  ILEN, 16  decode broadcast payload
- pcpi_valid  out  1  request active
- pcpi_insn, pcpi_prefix, pcpi_pc  out  ILEN, 16, XLEN  request payload
- pcpi_rs1/rs2/rs3_valid  out  1 each  operand valid
- pcpi_rs1/rs2/rs3_data  out  XLEN each  operands; indices insn[19:15], [24:20], [31:27]
- pcpi_ready  in  1  responder done
- pcpi_wb_valid  out  1  writeback accepted
- pcpi_wb_write, pcpi_wb_data  in  1, XLEN  writeback request
- pcpi_br_enable, pcpi_br_nextpc  in  1, XLEN  branch taken / target
- redirect_valid, redirect_pc  out  1, XLEN  one-cycle fetch redirect
- retire_valid, retire_pc  out  1, XLEN  one-cycle retire pulse
- trap  out  1  sticky timeout flag
- dbg_addr, dbg_data  in / out  5, XLEN  combinational register read

## Operation
- States: IDLE, DECODE, EXEC, TRAP. Reset -> IDLE, expected pc = RESET_PC, all registers zero.
- IDLE: fetch_ready=1. Accepted entry with fetch_pc != expected pc is dropped as wrong-path; stay IDLE, no decode. On a match, latch insn/prefix/pc -> DECODE.
- DECODE: decode_valid=1 with latched insn/prefix. pcpi_insn/prefix/pc are driven from latch in DECODE and EXEC. -> EXEC.
- EXEC: pcpi_valid=1, all rs*_valid=1, pcpi_wb_valid=1. Operands read combinationally; x0 reads 0. Timeout counter increments each cycle.
  - On pcpi_ready: if pcpi_wb_write and rd=insn[11:7]!=0, write pcpi_wb_data.
  - If pcpi_br_enable: expected pc = pcpi_br_nextpc, redirect pulse next cycle.
  - Else expected pc = pc + (prefix[1:0]==2'b11 ? 4 : 2), modulo 2^XLEN.
  - Retire pulse next cycle; -> IDLE.
  - Counter reaches TIMEOUT without ready -> TRAP.
- TRAP: trap=1, fetch_ready=0, no PCPI activity until reset.
- Writes to x0 are discarded. dbg_data reflects writes from the cycle after the write edge.

## Timing
- Reset values: every output 0 except redirect_pc/retire_pc=0 and fetch_ready=0 during reset; fetch_ready=1 the cycle after reset deasserts.
- Accept at edge T; decode_valid during cycle T+1; pcpi_valid from T+2 until the cycle pcpi_ready is sampled, inclusive.
- With a CPI=2 responder, 4 cycles per instruction; with CPI=1, 3 cycles.
- redirect_valid and retire_valid are registered and appear in the IDLE cycle after the ready edge, together with the new expected pc. A fetch entry presented in that same cycle is compared against the new pc.
- Reset mid-operation: abort at the next edge; no writeback, no pulses.
- pcpi_ready outside EXEC is ignored.

## Structure
- Shared package picorv_pkg: state enum, opcode/field-position constants, next-PC increment helper.
- One sub-module, picorv_regfile: 32xXLEN, three combinational read ports plus debug read, one synchronous write port, x0 hardwired, synchronous clear.

## Test plan
- ADDI x1,x0,5 (0x00500093) at pc 0, with a picorv_exec CPI=2 responder -> retire_pc=0 at cycle 4, dbg x1=5, expected pc=4.
- ADDI x0,x0,7 (0x00700013) -> retire pulse, dbg x0=0.
- BEQ x0,x0,+8 (0x00000463) at pc 4, then fetch entries pc 8 and pc 0xC -> redirect_pc=0xC; pc 8 dropped with no decode_valid; pc 0xC issued.
- JAL x1,+16 (0x010000ef) at pc 0x10 -> x1=0x14, redirect_pc=0x20. Compressed entry with prefix[1:0]=00 at pc 0x20 -> next expected pc 0x22.
- Responder never asserts ready -> trap=1 after 16 EXEC cycles, fetch_ready stays 0. Reset -> trap=0, pc=RESET_PC.
- Reset asserted in the second EXEC cycle of an ADDI x2 -> x2 remains 0, no retire pulse, IDLE after reset.
